// File: rtl/tb_sim_ctrl_csr.sv
// Simulation sequencer behind the VProc CSR bus.
// It holds the timeout value, the sticky error and partial-test flags,
// a free-running cycle counter and a saturating error-event counter.
// End-of-simulation requests pass through a drain phase. The phase ends
// once the DUT has been idle for DRAIN_CYCLES consecutive cycles, and
// then do_stop or do_finish is raised and held until reset.
module tb_sim_ctrl_csr #(
  parameter int unsigned DRAIN_CYCLES    = 16,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd100000,
  parameter int unsigned ERRCNT_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  csr_addr,
  input  logic        csr_write,
  input  logic [31:0] csr_wdata,
  input  logic        csr_read,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  input  logic        error_in,
  input  logic        dut_busy,
  output logic [31:0] timeout,
  output logic        error,
  output logic        do_stop,
  output logic        do_finish,
  output logic        partial_test,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_END   = 2'd2,
    ST_SPARE = 2'd3
  } state_e;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h1;
  localparam logic [3:0] ADDR_TIMEOUT = 4'h2;
  localparam logic [3:0] ADDR_CYCLES  = 4'h3;
  localparam logic [3:0] ADDR_ERRCNT  = 4'h4;

  localparam logic [7:0]              DRAIN_TARGET = 8'(DRAIN_CYCLES);
  localparam logic [ERRCNT_WIDTH-1:0] ERRCNT_MAX   = {ERRCNT_WIDTH{1'b1}};
  localparam logic [31:0]             CYCLES_MAX   = 32'hFFFF_FFFF;

  // Registered state
  state_e                  state_r;
  logic                    kind_finish_r;
  logic [7:0]              drain_cnt_r;
  logic                    do_stop_r;
  logic                    do_finish_r;
  logic                    error_r;
  logic                    partial_r;
  logic [31:0]             timeout_r;
  logic [31:0]             cycles_r;
  logic [ERRCNT_WIDTH-1:0] errcnt_r;
  logic [31:0]             rdata_r;
  logic                    rvalid_r;

  // Combinational next-state and decode
  state_e      state_nxt_s;
  logic        kind_finish_nxt_s;
  logic [7:0]  drain_cnt_nxt_s;
  logic        do_stop_nxt_s;
  logic        do_finish_nxt_s;
  logic        ctrl_wr_s;
  logic        finish_req_s;
  logic        stop_req_s;
  logic        set_partial_s;
  logic        set_error_s;
  logic        clr_error_s;
  logic        timeout_wr_s;
  logic        error_nxt_s;
  logic [31:0] status_s;
  logic [31:0] errcnt_ext_s;
  logic [31:0] rd_mux_s;

  assign ctrl_wr_s     = csr_write && (csr_addr == ADDR_CTRL);
  assign timeout_wr_s  = csr_write && (csr_addr == ADDR_TIMEOUT);
  assign finish_req_s  = ctrl_wr_s && csr_wdata[0];
  assign stop_req_s    = ctrl_wr_s && csr_wdata[1];
  assign set_partial_s = ctrl_wr_s && csr_wdata[2];
  assign set_error_s   = ctrl_wr_s && csr_wdata[3];
  assign clr_error_s   = ctrl_wr_s && csr_wdata[4];

  assign status_s     = {26'd0, kind_finish_r, dut_busy, state_r, partial_r, error_r};
  assign errcnt_ext_s = 32'(errcnt_r);

  // Sequencer next state: request latching, drain counting, end-of-sim outputs
  always_comb begin
    state_nxt_s       = state_r;
    kind_finish_nxt_s = kind_finish_r;
    drain_cnt_nxt_s   = drain_cnt_r;
    do_stop_nxt_s     = do_stop_r;
    do_finish_nxt_s   = do_finish_r;
    case (state_r)
      ST_RUN: begin
        if (finish_req_s || stop_req_s) begin
          state_nxt_s       = ST_DRAIN;
          kind_finish_nxt_s = finish_req_s;
          drain_cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // a finish request upgrades a stop; nothing downgrades a finish
        kind_finish_nxt_s = kind_finish_r | finish_req_s;
        if (drain_cnt_r == DRAIN_TARGET) begin
          state_nxt_s     = ST_END;
          do_finish_nxt_s = kind_finish_nxt_s;
          do_stop_nxt_s   = ~kind_finish_nxt_s;
        end else if (dut_busy) begin
          drain_cnt_nxt_s = 8'd0;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r + 8'd1;
        end
      end
      ST_END: begin
        // outputs and request kind hold until reset
        state_nxt_s = ST_END;
      end
      default: begin
        state_nxt_s       = ST_RUN;
        kind_finish_nxt_s = 1'b0;
        drain_cnt_nxt_s   = 8'd0;
        do_stop_nxt_s     = 1'b0;
        do_finish_nxt_s   = 1'b0;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      kind_finish_r <= 1'b0;
      drain_cnt_r   <= 8'd0;
      do_stop_r     <= 1'b0;
      do_finish_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      kind_finish_r <= kind_finish_nxt_s;
      drain_cnt_r   <= drain_cnt_nxt_s;
      do_stop_r     <= do_stop_nxt_s;
      do_finish_r   <= do_finish_nxt_s;
    end
  end

  // Sticky error: a set in the same cycle wins over a clear
  always_comb begin
    error_nxt_s = error_r;
    if (error_in || set_error_s) begin
      error_nxt_s = 1'b1;
    end else if (clr_error_s) begin
      error_nxt_s = 1'b0;
    end else begin
      error_nxt_s = error_r;
    end
  end

  // Error flag and partial-test flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r   <= 1'b0;
      partial_r <= 1'b0;
    end else begin
      error_r   <= error_nxt_s;
      partial_r <= partial_r | set_partial_s;
    end
  end

  // TIMEOUT register, writable in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_r <= TIMEOUT_DEFAULT;
    end else if (timeout_wr_s) begin
      timeout_r <= csr_wdata;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  // Saturating cycle and error-event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_r <= 32'd0;
      errcnt_r <= {ERRCNT_WIDTH{1'b0}};
    end else begin
      if (cycles_r != CYCLES_MAX) begin
        cycles_r <= cycles_r + 32'd1;
      end else begin
        cycles_r <= cycles_r;
      end
      if (error_in && (errcnt_r != ERRCNT_MAX)) begin
        errcnt_r <= errcnt_r + {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        errcnt_r <= errcnt_r;
      end
    end
  end

  // Read mux; it samples pre-write register values
  always_comb begin
    rd_mux_s = 32'd0;
    case (csr_addr)
      ADDR_STATUS:  rd_mux_s = status_s;
      ADDR_TIMEOUT: rd_mux_s = timeout_r;
      ADDR_CYCLES:  rd_mux_s = cycles_r;
      ADDR_ERRCNT:  rd_mux_s = errcnt_ext_s;
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Registered read response; data holds until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r  <= 32'd0;
      rvalid_r <= 1'b0;
    end else if (csr_read) begin
      rdata_r  <= rd_mux_s;
      rvalid_r <= 1'b1;
    end else begin
      rdata_r  <= rdata_r;
      rvalid_r <= 1'b0;
    end
  end

  assign csr_rdata    = rdata_r;
  assign csr_rvalid   = rvalid_r;
  assign timeout      = timeout_r;
  assign error        = error_r;
  assign do_stop      = do_stop_r;
  assign do_finish    = do_finish_r;
  assign partial_test = partial_r;
  assign state        = state_r;

endmodule

// File: tb/tb_tb_sim_ctrl_csr.sv
// Directed bench for tb_sim_ctrl_csr: inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-computed.
module tb_tb_sim_ctrl_csr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  csr_addr;
  logic        csr_write;
  logic [31:0] csr_wdata;
  logic        csr_read;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        error_in;
  logic        dut_busy;
  logic [31:0] timeout;
  logic        error;
  logic        do_stop;
  logic        do_finish;
  logic        partial_test;
  logic [1:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  tb_sim_ctrl_csr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_addr     (csr_addr),
    .csr_write    (csr_write),
    .csr_wdata    (csr_wdata),
    .csr_read     (csr_read),
    .csr_rdata    (csr_rdata),
    .csr_rvalid   (csr_rvalid),
    .error_in     (error_in),
    .dut_busy     (dut_busy),
    .timeout      (timeout),
    .error        (error),
    .do_stop      (do_stop),
    .do_finish    (do_finish),
    .partial_test (partial_test),
    .state        (state)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All tasks are entered on a falling edge and return on a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
    csr_wdata = 32'd0;
  endtask

  task automatic csr_rd(input string tag, input logic [3:0] a, output logic [31:0] d);
    csr_addr = a;
    csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, csr_rvalid}, 32'd1);
    d = csr_rdata;
  endtask

  task automatic do_reset();
    csr_write = 1'b0;
    csr_read  = 1'b0;
    error_in  = 1'b0;
    dut_busy  = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  // Counts falling edges until do_stop/do_finish rises; 0 if it never does
  task automatic wait_end(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (do_stop || do_finish) begin
        n = i;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  logic [31:0] rd2;
  int          lat;

  initial begin
    rst_n     = 1'b0;
    csr_addr  = 4'h0;
    csr_write = 1'b0;
    csr_wdata = 32'd0;
    csr_read  = 1'b0;
    error_in  = 1'b0;
    dut_busy  = 1'b0;

    // ---- reset values ----
    @(negedge clk);
    chk("rst_timeout", timeout, 32'd100000);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_flags", {27'd0, error, partial_test, do_stop, do_finish, csr_rvalid}, 32'd0);
    chk("rst_rdata", csr_rdata, 32'd0);
    rst_n = 1'b1;
    csr_rd("rst_cycles", 4'h3, rd);
    chk("rst_cycles", rd, 32'd0);
    step(5);
    csr_rd("cycles_adv", 4'h3, rd);
    chk("cycles_adv", rd, 32'd6);
    csr_rd("rst_status", 4'h1, rd);
    chk("rst_status", rd, 32'd0);
    step(1);
    chk("rvalid_one_cycle", {31'd0, csr_rvalid}, 32'd0);
    chk("rdata_hold", csr_rdata, 32'd0);
    csr_rd("rst_tmo", 4'h2, rd);
    chk("rst_tmo", rd, 32'd100000);
    csr_rd("rst_errcnt", 4'h4, rd);
    chk("rst_errcnt", rd, 32'd0);

    // ---- TIMEOUT readback and unmapped addresses ----
    csr_wr(4'h2, 32'h0000_1234);
    chk("tmo_out", timeout, 32'h0000_1234);
    csr_rd("tmo_rd", 4'h2, rd);
    chk("tmo_rd", rd, 32'h0000_1234);
    csr_wr(4'h7, 32'hFFFF_FFFF);
    csr_rd("unmapped_rd", 4'h7, rd);
    chk("unmapped_rd", rd, 32'd0);
    chk("unmapped_wr_ignored", timeout, 32'h0000_1234);
    // read and write to the same address in one cycle: read sees old value
    csr_addr  = 4'h2;
    csr_wdata = 32'h0000_0055;
    csr_write = 1'b1;
    csr_read  = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
    csr_read  = 1'b0;
    chk("rw_same_rdata", csr_rdata, 32'h0000_1234);
    chk("rw_same_tmo", timeout, 32'h0000_0055);

    // ---- drain sequencing with busy DUT ----
    do_reset();
    dut_busy = 1'b1;
    csr_wr(4'h0, 32'h1);
    chk("drain_enter", {30'd0, state}, 32'd1);
    step(4);
    dut_busy = 1'b0;
    wait_end(lat);
    chk("drain_latency", 32'(lat), 32'd17);
    chk("drain_finish", {31'd0, do_finish}, 32'd1);
    chk("drain_nostop", {31'd0, do_stop}, 32'd0);
    chk("end_state", {30'd0, state}, 32'd2);
    csr_wr(4'h0, 32'h2);
    step(2);
    chk("end_ignore_req", {30'd0, do_stop, do_finish}, 32'd1);
    csr_wr(4'h2, 32'h0000_0099);
    chk("end_tmo_live", timeout, 32'h0000_0099);
    csr_rd("end_status", 4'h1, rd);
    chk("end_status", rd, 32'h0000_0028);

    // ---- drain restart on busy pulse ----
    do_reset();
    chk("reset_clears_end", {29'd0, state, do_finish}, 32'd0);
    csr_wr(4'h0, 32'h1);
    step(10);
    dut_busy = 1'b1;
    step(1);
    dut_busy = 1'b0;
    chk("restart_no_end", {30'd0, do_stop, do_finish}, 32'd0);
    wait_end(lat);
    chk("restart_latency", 32'(lat), 32'd17);
    chk("restart_finish", {31'd0, do_finish}, 32'd1);

    // ---- request kinds ----
    do_reset();
    csr_wr(4'h0, 32'h3);
    wait_end(lat);
    chk("both_latency", 32'(lat), 32'd17);
    chk("both_outs", {30'd0, do_stop, do_finish}, 32'd1);

    do_reset();
    csr_wr(4'h0, 32'h2);
    wait_end(lat);
    chk("stop_latency", 32'(lat), 32'd17);
    chk("stop_outs", {30'd0, do_stop, do_finish}, 32'd2);

    do_reset();
    csr_wr(4'h0, 32'h2);
    csr_wr(4'h0, 32'h1);
    wait_end(lat);
    chk("upgrade_latency", 32'(lat), 32'd16);
    chk("upgrade_outs", {30'd0, do_stop, do_finish}, 32'd1);

    do_reset();
    csr_wr(4'h0, 32'h1);
    csr_wr(4'h0, 32'h2);
    wait_end(lat);
    chk("nodowngrade_latency", 32'(lat), 32'd16);
    chk("nodowngrade_outs", {30'd0, do_stop, do_finish}, 32'd1);

    // ---- error handling ----
    do_reset();
    error_in = 1'b1;
    step(3);
    error_in = 1'b0;
    chk("err_set", {31'd0, error}, 32'd1);
    csr_rd("errcnt3", 4'h4, rd);
    chk("errcnt3", rd, 32'd3);
    csr_wr(4'h0, 32'h10);
    chk("err_clr", {31'd0, error}, 32'd0);
    csr_wr(4'h0, 32'h18);
    chk("err_set_wins_ctrl", {31'd0, error}, 32'd1);
    csr_wr(4'h0, 32'h10);
    error_in = 1'b1;
    csr_wr(4'h0, 32'h10);
    error_in = 1'b0;
    chk("err_set_wins_in", {31'd0, error}, 32'd1);
    csr_wr(4'h0, 32'h4);
    chk("partial_set", {31'd0, partial_test}, 32'd1);
    csr_rd("err_status", 4'h1, rd);
    chk("err_status", rd, 32'h0000_0003);
    error_in = 1'b1;
    step(65531);
    error_in = 1'b0;
    csr_rd("errcnt_max", 4'h4, rd);
    chk("errcnt_max", rd, 32'h0000_FFFF);
    error_in = 1'b1;
    step(10);
    error_in = 1'b0;
    csr_rd("errcnt_sat", 4'h4, rd);
    chk("errcnt_sat", rd, 32'h0000_FFFF);

    // ---- asynchronous reset in DRAIN ----
    do_reset();
    csr_wr(4'h2, 32'h0000_0077);
    csr_wr(4'h0, 32'h0000_000C);
    dut_busy = 1'b1;
    csr_wr(4'h0, 32'h2);
    csr_rd("pre_rst_status", 4'h1, rd2);
    chk("pre_rst_status", rd2, 32'h0000_0017);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_timeout", timeout, 32'd100000);
    chk("async_rdata", csr_rdata, 32'd0);
    chk("async_flags", {27'd0, error, partial_test, do_stop, do_finish, csr_rvalid}, 32'd0);
    chk("async_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    dut_busy = 1'b0;
    step(1);
    chk("post_rst_state", {30'd0, state}, 32'd0);
    chk("post_rst_tmo", timeout, 32'd100000);
    csr_rd("post_rst_errcnt", 4'h4, rd);
    chk("post_rst_errcnt", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
